// File: rtl/score_overlay_if.sv
// Pixel bus between the raster timing generator and the score overlay:
// the current beam position goes in, the registered overlay colour/enable comes out.
interface score_overlay_if #(
  parameter int COLOR_BITS = 24
);
  localparam int CW = COLOR_BITS / 3;

  logic [9:0]    hpos_i;
  logic [9:0]    vpos_i;
  logic [CW-1:0] number_red_o;
  logic [CW-1:0] number_green_o;
  logic [CW-1:0] number_blue_o;
  logic          number_enable_o;

  modport master (
    output hpos_i, vpos_i,
    input  number_red_o, number_green_o, number_blue_o, number_enable_o
  );

  modport slave (
    input  hpos_i, vpos_i,
    output number_red_o, number_green_o, number_blue_o, number_enable_o
  );
endinterface

// File: rtl/score_overlay.sv
// Per-player BCD score counters with win latch and blink, rendered as 16x16
// seven-segment glyphs over the playfield with one cycle of pixel latency.
module score_overlay #(
  parameter int                    COLOR_BITS   = 24,
  parameter int                    NUM_PLAYERS  = 2,
  parameter int                    DIGITS       = 2,
  parameter int                    WIN_SCORE    = 10,
  parameter int                    BASE_X       = 480,
  parameter int                    BASE_Y       = 160,
  parameter int                    PLAYER_PITCH = 96,
  parameter int                    BLINK_FRAMES = 32,
  parameter logic [COLOR_BITS-1:0] FG_COLOR     = 24'h000000,
  parameter logic [COLOR_BITS-1:0] BG_COLOR     = 24'hE0E0E0
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NUM_PLAYERS-1:0]          score_inc_i,
  input  logic                            score_clr_i,
  input  logic                            frame_start_i,
  output logic [NUM_PLAYERS*DIGITS*4-1:0] score_o,
  output logic [NUM_PLAYERS-1:0]          winner_o,
  score_overlay_if.slave                  pix
);

  localparam int CW = COLOR_BITS / 3;
  localparam int SW = DIGITS * 4;
  localparam int BW = ($clog2(BLINK_FRAMES + 1) > 3) ? $clog2(BLINK_FRAMES + 1) : 3;
  localparam logic [SW-1:0] ALL_NINES = {DIGITS{4'h9}};

  logic [SW-1:0]          score_q   [NUM_PLAYERS];
  logic [SW-1:0]          score_nxt [NUM_PLAYERS];
  logic [BW-1:0]          blink_cnt [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] winner_q;
  logic [NUM_PLAYERS-1:0] counted;
  logic [NUM_PLAYERS-1:0] win_hit;
  logic [NUM_PLAYERS-1:0] hidden;
  logic [4:0]             frame_cnt;
  logic                   pix_hit;
  logic [COLOR_BITS-1:0]  pix_color;

  function automatic logic [SW-1:0] bcd_inc(input logic [SW-1:0] v);
    logic [SW-1:0] r;
    logic          carry;
    r     = v;
    carry = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (carry) begin
        if (v[k*4 +: 4] == 4'd9) begin
          r[k*4 +: 4] = 4'd0;
        end else begin
          r[k*4 +: 4] = v[k*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic int bcd_value(input logic [SW-1:0] v);
    int acc;
    acc = 0;
    for (int k = DIGITS - 1; k >= 0; k--) acc = acc * 10 + int'(v[k*4 +: 4]);
    return acc;
  endfunction

  // Digit k counts from the MS end; leading zeros become code 10 (blank).
  function automatic logic [3:0] glyph_code(input logic [SW-1:0] v, input int k);
    logic lead;
    lead = 1'b1;
    for (int j = DIGITS - 1; j >= DIGITS - 1 - k; j--) begin
      if (v[j*4 +: 4] != 4'd0) lead = 1'b0;
    end
    if (lead && (k != DIGITS - 1)) return 4'd10;
    return v[(DIGITS-1-k)*4 +: 4];
  endfunction

  function automatic logic glyph_pixel(input logic [3:0] code, input logic [3:0] col,
                                       input logic [3:0] row);
    logic [6:0] seg;
    logic       hbar, top, mid, bot, lcol, rcol, upper, lower;
    case (code)
      4'd0: seg = 7'b1111110;
      4'd1: seg = 7'b0110000;
      4'd2: seg = 7'b1101101;
      4'd3: seg = 7'b1111001;
      4'd4: seg = 7'b0110011;
      4'd5: seg = 7'b1011011;
      4'd6: seg = 7'b1011111;
      4'd7: seg = 7'b1110000;
      4'd8: seg = 7'b1111111;
      4'd9: seg = 7'b1111011;
      default: seg = 7'b0000000;
    endcase
    hbar  = (col >= 4'd3) && (col <= 4'd12);
    lcol  = (col == 4'd3) || (col == 4'd4);
    rcol  = (col == 4'd11) || (col == 4'd12);
    top   = (row == 4'd1) || (row == 4'd2);
    mid   = (row == 4'd7) || (row == 4'd8);
    bot   = (row == 4'd13) || (row == 4'd14);
    upper = (row >= 4'd1) && (row <= 4'd8);
    lower = (row >= 4'd7) && (row <= 4'd14);
    return (seg[6] & top & hbar) | (seg[5] & rcol & upper) | (seg[4] & rcol & lower) |
           (seg[3] & bot & hbar) | (seg[2] & lcol & lower) | (seg[1] & lcol & upper) |
           (seg[0] & mid & hbar);
  endfunction

  // An increment counts only when no winner exists yet and the player is not saturated.
  always_comb begin
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      score_nxt[p] = bcd_inc(score_q[p]);
      counted[p]   = score_inc_i[p] && !(|winner_q) && (score_q[p] != ALL_NINES);
      win_hit[p]   = counted[p] && (WIN_SCORE != 0) && (bcd_value(score_nxt[p]) == WIN_SCORE);
      hidden[p]    = ((blink_cnt[p] != '0) && blink_cnt[p][2]) || (winner_q[p] && frame_cnt[4]);
      score_o[p*SW +: SW] = score_q[p];
    end
    winner_o = winner_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        score_q[p]   <= '0;
        blink_cnt[p] <= '0;
      end
      winner_q  <= '0;
      frame_cnt <= '0;
    end else begin
      if (frame_start_i) frame_cnt <= frame_cnt + 5'd1;
      if (score_clr_i) begin
        for (int p = 0; p < NUM_PLAYERS; p++) begin
          score_q[p]   <= '0;
          blink_cnt[p] <= '0;
        end
        winner_q <= '0;
      end else begin
        for (int p = 0; p < NUM_PLAYERS; p++) begin
          if (counted[p]) begin
            score_q[p]   <= score_nxt[p];
            blink_cnt[p] <= BW'(BLINK_FRAMES);
          end else if (frame_start_i && (blink_cnt[p] != '0)) begin
            blink_cnt[p] <= blink_cnt[p] - 1'b1;
          end
          if (win_hit[p]) winner_q[p] <= 1'b1;
        end
      end
    end
  end

  // Scan players high to low so the lowest-numbered overlapping field wins.
  always_comb begin
    int x0;
    int dx;
    int dy;
    pix_hit   = 1'b0;
    pix_color = '0;
    x0        = 0;
    dx        = 0;
    dy        = int'(pix.vpos_i) - BASE_Y;
    for (int p = NUM_PLAYERS - 1; p >= 0; p--) begin
      for (int k = 0; k < DIGITS; k++) begin
        x0 = BASE_X + p * PLAYER_PITCH + k * 16;
        dx = int'(pix.hpos_i) - x0;
        if ((dx >= 0) && (dx < 16) && (dy >= 0) && (dy < 16)) begin
          pix_hit = 1'b1;
          if (!hidden[p] && glyph_pixel(glyph_code(score_q[p], k), 4'(dx), 4'(dy)))
            pix_color = FG_COLOR;
          else
            pix_color = BG_COLOR;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pix.number_red_o    <= '0;
      pix.number_green_o  <= '0;
      pix.number_blue_o   <= '0;
      pix.number_enable_o <= 1'b0;
    end else begin
      pix.number_red_o    <= pix_color[COLOR_BITS-1 -: CW];
      pix.number_green_o  <= pix_color[2*CW-1 -: CW];
      pix.number_blue_o   <= pix_color[CW-1:0];
      pix.number_enable_o <= pix_hit;
    end
  end

endmodule

// File: tb/tb_score_overlay.sv
// Directed bench for score_overlay: a default instance (win at 10) and a
// second instance with win detection disabled for saturation behaviour.
module tb_score_overlay;

  localparam logic [23:0] FG = 24'h000000;
  localparam logic [23:0] BG = 24'hE0E0E0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  inc_a = 2'b00;
  logic [1:0]  inc_b = 2'b00;
  logic        clr = 1'b0;
  logic        frame = 1'b0;
  logic [15:0] score_a, score_b;
  logic [1:0]  winner_a, winner_b;
  int          checks = 0;
  int          errors = 0;

  score_overlay_if #(.COLOR_BITS(24)) pix_a ();
  score_overlay_if #(.COLOR_BITS(24)) pix_b ();

  score_overlay dut_a (
    .clk_i(clk), .rst_i(rst), .score_inc_i(inc_a), .score_clr_i(clr),
    .frame_start_i(frame), .score_o(score_a), .winner_o(winner_a), .pix(pix_a)
  );

  score_overlay #(.WIN_SCORE(0)) dut_b (
    .clk_i(clk), .rst_i(rst), .score_inc_i(inc_b), .score_clr_i(clr),
    .frame_start_i(frame), .score_o(score_b), .winner_o(winner_b), .pix(pix_b)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] color_a();
    return {pix_a.number_red_o, pix_a.number_green_o, pix_a.number_blue_o};
  endfunction

  function automatic logic [23:0] color_b();
    return {pix_b.number_red_o, pix_b.number_green_o, pix_b.number_blue_o};
  endfunction

  task automatic drive_pixel(input int x, input int y);
    @(negedge clk);
    pix_a.hpos_i = 10'(x);
    pix_a.vpos_i = 10'(y);
    pix_b.hpos_i = 10'(x);
    pix_b.vpos_i = 10'(y);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_inc(input logic [1:0] ma, input logic [1:0] mb, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      inc_a = ma;
      inc_b = mb;
      @(negedge clk);
      inc_a = 2'b00;
      inc_b = 2'b00;
    end
  endtask

  task automatic pulse_frames(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      frame = 1'b1;
      @(negedge clk);
      frame = 1'b0;
    end
  endtask

  task automatic test_reset();
    pix_a.hpos_i = 10'd0; pix_a.vpos_i = 10'd0;
    pix_b.hpos_i = 10'd0; pix_b.vpos_i = 10'd0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (score_a !== 16'h0000 || winner_a !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_state score=%h winner=%b, want 0000/00", score_a, winner_a);
    end
    checks++;
    if (pix_a.number_enable_o !== 1'b0 || color_a() !== 24'h0) begin
      errors++;
      $display("[TB] FAIL reset_pixel en=%b col=%h, want 0/000000", pix_a.number_enable_o, color_a());
    end
    @(negedge clk);
    rst = 1'b0;
    drive_pixel(480, 160);
    checks++;
    if (pix_a.number_enable_o !== 1'b1 || color_a() !== BG) begin
      errors++;
      $display("[TB] FAIL field_corner en=%b col=%h, want 1/%h", pix_a.number_enable_o, color_a(), BG);
    end
    drive_pixel(501, 161);
    checks++;
    if (color_a() !== FG) begin
      errors++;
      $display("[TB] FAIL ls_zero_glyph col=%h, want %h", color_a(), FG);
    end
    drive_pixel(485, 161);
    checks++;
    if (color_a() !== BG) begin
      errors++;
      $display("[TB] FAIL ms_blank col=%h, want %h", color_a(), BG);
    end
    drive_pixel(479, 160);
    checks++;
    if (pix_a.number_enable_o !== 1'b0 || color_a() !== 24'h0) begin
      errors++;
      $display("[TB] FAIL left_edge en=%b col=%h, want 0/000000", pix_a.number_enable_o, color_a());
    end
    drive_pixel(512, 161);
    checks++;
    if (pix_a.number_enable_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL right_edge en=%b, want 0", pix_a.number_enable_o);
    end
    drive_pixel(501, 176);
    checks++;
    if (pix_a.number_enable_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bottom_edge en=%b, want 0", pix_a.number_enable_o);
    end
  endtask

  task automatic test_increment();
    pulse_inc(2'b01, 2'b00, 9);
    checks++;
    if (score_a[7:0] !== 8'h09 || winner_a !== 2'b00) begin
      errors++;
      $display("[TB] FAIL inc_to_9 score=%h winner=%b, want 09/00", score_a[7:0], winner_a);
    end
    drive_pixel(501, 161);
    checks++;
    if (color_a() !== FG) begin
      errors++;
      $display("[TB] FAIL nine_glyph col=%h, want %h", color_a(), FG);
    end
    pulse_inc(2'b01, 2'b00, 1);
    checks++;
    if (score_a[7:0] !== 8'h10 || winner_a !== 2'b01) begin
      errors++;
      $display("[TB] FAIL inc_carry score=%h winner=%b, want 10/01", score_a[7:0], winner_a);
    end
    drive_pixel(491, 163);
    checks++;
    if (color_a() !== FG) begin
      errors++;
      $display("[TB] FAIL ms_one_glyph col=%h, want %h", color_a(), FG);
    end
    drive_pixel(485, 161);
    checks++;
    if (color_a() !== BG) begin
      errors++;
      $display("[TB] FAIL ms_one_top col=%h, want %h", color_a(), BG);
    end
  endtask

  task automatic test_winner();
    pulse_inc(2'b10, 2'b00, 1);
    checks++;
    if (score_a[15:8] !== 8'h00 || winner_a !== 2'b01) begin
      errors++;
      $display("[TB] FAIL inc_after_win p1=%h winner=%b, want 00/01", score_a[15:8], winner_a);
    end
    pulse_frames(16);
    drive_pixel(491, 163);
    checks++;
    if (pix_a.number_enable_o !== 1'b1 || color_a() !== BG) begin
      errors++;
      $display("[TB] FAIL winner_hidden en=%b col=%h, want 1/%h", pix_a.number_enable_o, color_a(), BG);
    end
    drive_pixel(597, 161);
    checks++;
    if (color_a() !== FG) begin
      errors++;
      $display("[TB] FAIL loser_visible col=%h, want %h", color_a(), FG);
    end
    pulse_frames(16);
    drive_pixel(491, 163);
    checks++;
    if (color_a() !== FG) begin
      errors++;
      $display("[TB] FAIL winner_shown col=%h, want %h", color_a(), FG);
    end
  endtask

  task automatic test_clear_priority();
    @(negedge clk);
    clr = 1'b1;
    inc_a = 2'b11;
    @(negedge clk);
    clr = 1'b0;
    inc_a = 2'b00;
    checks++;
    if (score_a !== 16'h0000 || winner_a !== 2'b00) begin
      errors++;
      $display("[TB] FAIL clr_priority score=%h winner=%b, want 0000/00", score_a, winner_a);
    end
    pulse_frames(4);
    drive_pixel(501, 161);
    checks++;
    if (color_a() !== FG) begin
      errors++;
      $display("[TB] FAIL clr_no_blink col=%h, want %h", color_a(), FG);
    end
  endtask

  task automatic test_blink();
    pulse_inc(2'b01, 2'b00, 1);
    checks++;
    if (score_a[7:0] !== 8'h01) begin
      errors++;
      $display("[TB] FAIL inc_after_clr score=%h, want 01", score_a[7:0]);
    end
    drive_pixel(507, 163);
    checks++;
    if (color_a() !== FG) begin
      errors++;
      $display("[TB] FAIL blink_cnt32 col=%h, want %h", color_a(), FG);
    end
    pulse_frames(4);
    drive_pixel(507, 163);
    checks++;
    if (color_a() !== BG) begin
      errors++;
      $display("[TB] FAIL blink_cnt28 col=%h, want %h", color_a(), BG);
    end
    pulse_frames(4);
    drive_pixel(507, 163);
    checks++;
    if (color_a() !== FG) begin
      errors++;
      $display("[TB] FAIL blink_cnt24 col=%h, want %h", color_a(), FG);
    end
    pulse_frames(4);
    drive_pixel(507, 163);
    checks++;
    if (color_a() !== BG) begin
      errors++;
      $display("[TB] FAIL blink_cnt20 col=%h, want %h", color_a(), BG);
    end
    pulse_frames(20);
    drive_pixel(507, 163);
    checks++;
    if (color_a() !== FG) begin
      errors++;
      $display("[TB] FAIL blink_done col=%h, want %h", color_a(), FG);
    end
  endtask

  task automatic test_saturation();
    pulse_inc(2'b00, 2'b01, 99);
    checks++;
    if (score_b[7:0] !== 8'h99 || winner_b !== 2'b00) begin
      errors++;
      $display("[TB] FAIL sat_99 score=%h winner=%b, want 99/00", score_b[7:0], winner_b);
    end
    pulse_frames(12);
    pulse_inc(2'b00, 2'b01, 1);
    checks++;
    if (score_b !== 16'h0099) begin
      errors++;
      $display("[TB] FAIL sat_hold score=%h, want 0099", score_b);
    end
    drive_pixel(501, 161);
    checks++;
    if (pix_b.number_enable_o !== 1'b1 || color_b() !== BG) begin
      errors++;
      $display("[TB] FAIL sat_no_reload en=%b col=%h, want 1/%h", pix_b.number_enable_o, color_b(), BG);
    end
  endtask

  task automatic test_reset_midline();
    drive_pixel(490, 161);
    checks++;
    if (pix_a.number_enable_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pre_reset_en en=%b, want 1", pix_a.number_enable_o);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (pix_a.number_enable_o !== 1'b0 || color_a() !== 24'h0 || score_a !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL async_reset en=%b col=%h score=%h, want 0/000000/0000",
               pix_a.number_enable_o, color_a(), score_a);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (pix_a.number_enable_o !== 1'b1 || color_a() !== BG) begin
      errors++;
      $display("[TB] FAIL resume_after_reset en=%b col=%h, want 1/%h", pix_a.number_enable_o, color_a(), BG);
    end
  endtask

  initial begin
    test_reset();
    test_increment();
    test_winner();
    test_clear_priority();
    test_blink();
    test_saturation();
    test_reset_midline();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
